// File: rtl/mem_arb_pkg.sv
// Shared types for the fetch/data memory port arbiter: FSM states, owner
// encoding and the load/store type codes also used by the LSU and decoder.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWNER_I = 1'b0,
    OWNER_D = 1'b1
  } owner_e;

  localparam logic [2:0] LS_LW  = 3'd0;
  localparam logic [2:0] LS_LH  = 3'd1;
  localparam logic [2:0] LS_LB  = 3'd2;
  localparam logic [2:0] LS_LHU = 3'd3;
  localparam logic [2:0] LS_LBU = 3'd4;
  localparam logic [2:0] LS_SW  = 3'd5;
  localparam logic [2:0] LS_SH  = 3'd6;
  localparam logic [2:0] LS_SB  = 3'd7;

  function automatic owner_e owner_of(arb_state_e s);
    return (s == BUSY_D) ? OWNER_D : OWNER_I;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Core-side request/response channels plus the memory handshake, bundled so
// the arbiter sees them through the slave modport.
interface mem_port_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [2:0]  d_type;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [2:0]  mem_type;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        bus_err;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_type, d_addr, d_wdata,
           mem_ack, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           mem_req, mem_we, mem_type, mem_addr, mem_wdata, bus_err
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_type, d_addr, d_wdata,
           mem_ack, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           mem_req, mem_we, mem_type, mem_addr, mem_wdata, bus_err
  );
endinterface

// File: rtl/mem_port_arbiter_pick.sv
// Winner selection between fetch and data requests, with a saturating count
// of data grants that bypassed a waiting fetch.
module arb_pick
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic idle,
  input  logic if_req,
  input  logic d_req,
  output logic if_gnt,
  output logic d_gnt
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] starve_cnt_q, starve_cnt_d;

  // Grants are gated by reset so every output is quiet while rst is held.
  always_comb begin
    if_gnt       = 1'b0;
    d_gnt        = 1'b0;
    starve_cnt_d = starve_cnt_q;
    if (idle && !rst) begin
      if (d_req && !(if_req && starve_cnt_q == LIMIT)) begin
        d_gnt = 1'b1;
        if (if_req && starve_cnt_q != LIMIT) starve_cnt_d = starve_cnt_q + 4'd1;
      end else if (if_req) begin
        if_gnt       = 1'b1;
        starve_cnt_d = 4'd0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) starve_cnt_q <= 4'd0;
    else     starve_cnt_q <= starve_cnt_d;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one variable-latency memory port between instruction fetch and data
// accesses: latches the winner, runs the handshake, routes the response back.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 64
) (
  input logic              clk,
  input logic              rst,
  mem_port_arbiter_if.slave bus
);

  localparam bit          TO_EN   = (TIMEOUT != 0);
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  arb_state_e  state_q, state_d;
  logic [15:0] wait_cnt_q, wait_cnt_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [2:0]  mem_type_q, mem_type_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        if_rvalid_q, if_rvalid_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic        d_rvalid_q, d_rvalid_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        bus_err_q, bus_err_d;
  logic        if_gnt, d_gnt;

  arb_pick #(.STARVE_LIMIT(STARVE_LIMIT)) u_pick (
    .clk    (clk),
    .rst    (rst),
    .idle   (state_q == IDLE),
    .if_req (bus.if_req),
    .d_req  (bus.d_req),
    .if_gnt (if_gnt),
    .d_gnt  (d_gnt)
  );

  // An ack in the final timeout cycle takes precedence over the abort.
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_type_d  = mem_type_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rvalid_d = 1'b0;
    if_rdata_d  = 32'd0;
    d_rvalid_d  = 1'b0;
    d_rdata_d   = 32'd0;
    bus_err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (d_gnt) begin
          state_d     = BUSY_D;
          mem_req_d   = 1'b1;
          mem_we_d    = bus.d_we;
          mem_type_d  = bus.d_type;
          mem_addr_d  = bus.d_addr;
          mem_wdata_d = bus.d_wdata;
          wait_cnt_d  = 16'd0;
        end else if (if_gnt) begin
          state_d     = BUSY_I;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_type_d  = LS_LW;
          mem_addr_d  = bus.if_addr;
          mem_wdata_d = 32'd0;
          wait_cnt_d  = 16'd0;
        end
      end
      BUSY_I, BUSY_D: begin
        if (bus.mem_ack) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          if (owner_of(state_q) == OWNER_D) begin
            d_rvalid_d = 1'b1;
            d_rdata_d  = mem_we_q ? 32'd0 : bus.mem_rdata;
          end else begin
            if_rvalid_d = 1'b1;
            if_rdata_d  = bus.mem_rdata;
          end
        end else if (TO_EN && wait_cnt_q == TO_LAST) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          bus_err_d = 1'b1;
          if (owner_of(state_q) == OWNER_D) d_rvalid_d  = 1'b1;
          else                              if_rvalid_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 16'd1;
        end
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      wait_cnt_q  <= 16'd0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_type_q  <= 3'd0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      if_rvalid_q <= 1'b0;
      if_rdata_q  <= 32'd0;
      d_rvalid_q  <= 1'b0;
      d_rdata_q   <= 32'd0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_type_q  <= mem_type_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rvalid_q <= if_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      d_rvalid_q  <= d_rvalid_d;
      d_rdata_q   <= d_rdata_d;
      bus_err_q   <= bus_err_d;
    end
  end

  assign bus.if_gnt    = if_gnt;
  assign bus.d_gnt     = d_gnt;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_type  = mem_type_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.if_rvalid = if_rvalid_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_rvalid  = d_rvalid_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.bus_err   = bus_err_q;

endmodule
